// File: rtl/scan_ctrl_pkg.sv
// Shared types and defaults for the scan test controller.
package scan_ctrl_pkg;

   localparam int DEF_CHAIN_LEN      = 4;
   localparam int DEF_CAPTURE_CYCLES = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_UNLOAD  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Counter only ever reaches max(len, capture) - 1 before the state changes.
   function automatic int cnt_width(input int chain_len, input int capture_cycles);
      int m;
      m = (chain_len > capture_cycles) ? chain_len : capture_cycles;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/scan_ctrl_shreg.sv
// Parallel-load register that shifts toward the MSB with serial data entering the LSB.
module scan_ctrl_shreg #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_shift,
   input  logic         i_sin,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_val;
      end else if (i_shift) begin
         r_q <= {r_q[W-2:0], i_sin};
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/scan_ctrl.sv
// Scan chain test sequencer: load pattern, capture, unload and compare.
// Optional SCAN_CTRL_MASK_EN adds a don't-care mask on the comparison.
module scan_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter int CHAIN_LEN      = DEF_CHAIN_LEN,
   parameter int CAPTURE_CYCLES = DEF_CAPTURE_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pattern,
   input  logic [CHAIN_LEN-1:0] expected,
`ifdef SCAN_CTRL_MASK_EN
   input  logic [CHAIN_LEN-1:0] mask,
`endif
   input  logic                 so,
   output logic                 se,
   output logic                 si,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CHAIN_LEN-1:0] response
);

   localparam int             CW         = cnt_width(CHAIN_LEN, CAPTURE_CYCLES);
   localparam logic [CW-1:0]  LAST_CHAIN = CW'(CHAIN_LEN - 1);
   localparam logic [CW-1:0]  LAST_CAP   = CW'(CAPTURE_CYCLES - 1);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [CW-1:0]          r_cnt;
   logic [CHAIN_LEN-1:0]   r_expected;
   logic                   r_pass;
   logic [CHAIN_LEN-1:0]   w_pat_q;
   logic                   w_accept;
   logic                   w_match;

`ifdef SCAN_CTRL_MASK_EN
   logic [CHAIN_LEN-1:0]   r_mask;
   assign w_match = ((response ^ r_expected) & ~r_mask) == '0;
`else
   assign w_match = (response == r_expected);
`endif

   assign w_accept = (r_state == ST_IDLE) && start;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (start)               w_state_next = ST_LOAD;
         ST_LOAD:    if (r_cnt == LAST_CHAIN) w_state_next = ST_CAPTURE;
         ST_CAPTURE: if (r_cnt == LAST_CAP)   w_state_next = ST_UNLOAD;
         ST_UNLOAD:  if (r_cnt == LAST_CHAIN) w_state_next = ST_DONE;
         ST_DONE:                             w_state_next = ST_IDLE;
         default:                             w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_expected <= '0;
         r_pass     <= 1'b0;
`ifdef SCAN_CTRL_MASK_EN
         r_mask     <= '0;
`endif
      end else begin
         r_state <= w_state_next;
         // Restarting at zero on every transition keeps the count from ever wrapping.
         if (w_state_next != r_state) begin
            r_cnt <= '0;
         end else if (r_state != ST_IDLE) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_accept) begin
            r_expected <= expected;
            r_pass     <= 1'b0;
`ifdef SCAN_CTRL_MASK_EN
            r_mask     <= mask;
`endif
         end else if (r_state == ST_DONE) begin
            r_pass <= w_match;
         end
      end
   end

   scan_ctrl_shreg #(.W(CHAIN_LEN)) u_pattern (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_accept),
      .i_load_val (pattern),
      .i_shift    (r_state == ST_LOAD),
      .i_sin      (1'b0),
      .o_q        (w_pat_q)
   );

   scan_ctrl_shreg #(.W(CHAIN_LEN)) u_response (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_shift    (r_state == ST_UNLOAD),
      .i_sin      (so),
      .o_q        (response)
   );

   assign se   = (r_state == ST_LOAD) || (r_state == ST_UNLOAD);
   assign si   = (r_state == ST_LOAD) && w_pat_q[CHAIN_LEN-1];
   assign busy = (r_state != ST_IDLE);
   assign done = (r_state == ST_DONE);
   // In DONE the freshly unloaded response is compared live; afterwards the held result shows.
   assign pass = (r_state == ST_DONE) ? w_match : r_pass;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: two instances (capture 1 and 3) driving behavioural scan chains.
`timescale 1ns/1ps
module tb_scan_ctrl;

   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset_n;
   logic [1:0]         start_r;
   logic [1:0][N-1:0]  pat_r, exp_r, mask_r;
   int                 mode_r [2];   // 0: loopback chain, 1: up-counter chain
   logic [1:0]         se_w, si_w, busy_w, done_w, pass_w, so_w;
   logic [1:0][N-1:0]  resp_w;

   int checks = 0;
   int errors = 0;

   function automatic int ccyc(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      logic [N-1:0] chain = '0;

      scan_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(gi == 0 ? 1 : 3)) u_dut (
         .clk      (clk),
         .reset_n  (reset_n),
         .start    (start_r[gi]),
         .pattern  (pat_r[gi]),
         .expected (exp_r[gi]),
`ifdef SCAN_CTRL_MASK_EN
         .mask     (mask_r[gi]),
`endif
         .so       (so_w[gi]),
         .se       (se_w[gi]),
         .si       (si_w[gi]),
         .busy     (busy_w[gi]),
         .done     (done_w[gi]),
         .pass     (pass_w[gi]),
         .response (resp_w[gi])
      );

      // Chain under test: flop 0 is the head, flop N-1 the tail.
      always @(posedge clk) begin
         if (se_w[gi])             chain <= {chain[N-2:0], si_w[gi]};
         else if (mode_r[gi] == 1) chain <= chain + 1'b1;
      end
      assign so_w[gi] = chain[N-1];
   end

   // Reference model: k is the cycle number since the accepted start (0 = idle).
   int           k      [2];
   int           m_mode [2];
   logic [N-1:0] m_pat  [2], m_exp [2], m_mask [2], m_resp [2];
   logic         m_pass [2];

   function automatic int last_k(input int i);
      return 2 * N + ccyc(i) + 1;
   endfunction

   function automatic logic [N-1:0] model_resp(input int i);
      return (m_mode[i] == 0) ? m_pat[i] : m_pat[i] + N'(ccyc(i));
   endfunction

   always @(posedge clk or negedge reset_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            k[i]      <= 0;
            m_resp[i] <= '0;
            m_pass[i] <= 1'b0;
         end else if (k[i] == 0) begin
            if (start_r[i]) begin
               k[i]      <= 1;
               m_pat[i]  <= pat_r[i];
               m_exp[i]  <= exp_r[i];
               m_mask[i] <= mask_r[i];
               m_mode[i] <= mode_r[i];
               m_pass[i] <= 1'b0;
            end
         end else if (k[i] == last_k(i)) begin
            k[i] <= 0;
         end else begin
            k[i] <= k[i] + 1;
            if (k[i] + 1 == last_k(i)) begin
               m_resp[i] <= model_resp(i);
               m_pass[i] <= ((model_resp(i) ^ m_exp[i]) & ~m_mask[i]) == '0;
            end
         end
      end
   end

   task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t got %0h want %0h", name, inst, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            chk("rst_busy", i, busy_w[i], 0);
            chk("rst_se",   i, se_w[i],   0);
            chk("rst_si",   i, si_w[i],   0);
            chk("rst_done", i, done_w[i], 0);
            chk("rst_pass", i, pass_w[i], 0);
            chk("rst_resp", i, resp_w[i], 0);
         end else begin
            int  kk;
            bit  in_load, in_unload;
            kk        = k[i];
            in_load   = (kk >= 1) && (kk <= N);
            in_unload = (kk > N + ccyc(i)) && (kk <= 2 * N + ccyc(i));
            chk("busy", i, busy_w[i], kk != 0);
            chk("se",   i, se_w[i],   in_load || in_unload);
            chk("si",   i, si_w[i],   in_load ? m_pat[i][N-kk] : 1'b0);
            chk("done", i, done_w[i], kk == last_k(i));
            if (kk == 0 || kk == last_k(i)) begin
               chk("resp", i, resp_w[i], m_resp[i]);
               chk("pass", i, pass_w[i], m_pass[i]);
            end else begin
               chk("pass_busy", i, pass_w[i], 0);
            end
         end
      end
   end

   task automatic wait_done(input int i, input int want_lat, input logic [N-1:0] want_resp, input logic want_pass);
      int cnt;
      cnt = 1;
      while (!done_w[i] && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk("latency",  i, cnt,        want_lat);
      chk("resp_lit", i, resp_w[i],  want_resp);
      chk("pass_lit", i, pass_w[i],  want_pass);
      $display("test inst%0d pattern=%b expected=%b response=%b pass=%b latency=%0d",
               i, pat_r[i], exp_r[i], resp_w[i], pass_w[i], cnt);
      @(negedge clk);
      chk("pass_hold", i, pass_w[i], want_pass);
      chk("resp_hold", i, resp_w[i], want_resp);
   endtask

   task automatic run_test(input int i, input logic [N-1:0] p, input logic [N-1:0] e, input int md,
                           input logic [N-1:0] want_resp, input logic want_pass, input int want_lat);
      mode_r[i]  = md;
      pat_r[i]   = p;
      exp_r[i]   = e;
      start_r[i] = 1'b1;
      @(negedge clk);
      start_r[i] = 1'b0;
      wait_done(i, want_lat, want_resp, want_pass);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int dones;
      reset_n   = 1'b0;
      start_r   = '0;
      pat_r     = '0;
      exp_r     = '0;
      mask_r    = '0;
      mode_r[0] = 0;
      mode_r[1] = 0;
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);

      // Loopback chain: response mirrors the pattern, done 10 cycles after start.
      run_test(0, 4'b1010, 4'b1010, 0, 4'b1010, 1'b1, 10);
      // Counter chain, one capture cycle: 3 + 1 = 4.
      run_test(0, 4'b0011, 4'b0100, 1, 4'b0100, 1'b1, 10);
      run_test(0, 4'b0011, 4'b0101, 1, 4'b0100, 1'b0, 10);
      // Three capture cycles: 14 + 3 wraps to 1, done 12 cycles after start.
      run_test(1, 4'b1110, 4'b0001, 1, 4'b0001, 1'b1, 12);

      // Start re-pulsed during LOAD and during DONE is ignored; next IDLE cycle accepts.
      mode_r[0]  = 0;
      pat_r[0]   = 4'b0110;
      exp_r[0]   = 4'b0110;
      start_r[0] = 1'b1;
      @(negedge clk);
      dones = 0;
      for (int c = 1; c <= 11; c++) begin
         if (done_w[0]) dones++;
         if (c == 10) begin
            pat_r[0] = 4'b1001;
            exp_r[0] = 4'b1001;
         end
         start_r[0] = (c == 2) || (c == 10) || (c == 11);
         @(negedge clk);
      end
      start_r[0] = 1'b0;
      chk("busy_single_done", 0, dones, 1);
      wait_done(0, 10, 4'b1001, 1'b1);

      // Reset just after edge T+6 aborts the test.
      pat_r[0]   = 4'b0101;
      exp_r[0]   = 4'b0101;
      start_r[0] = 1'b1;
      @(negedge clk);
      start_r[0] = 1'b0;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("async_se",   0, se_w[0],   0);
      chk("async_busy", 0, busy_w[0], 0);
      chk("async_resp", 0, resp_w[0], 0);
      @(negedge clk);
      #1 reset_n = 1'b1;
      dones = 0;
      repeat (15) begin
         @(negedge clk);
         if (done_w[0]) dones++;
      end
      chk("no_done_after_reset", 0, dones, 0);
      run_test(0, 4'b0101, 4'b0101, 0, 4'b0101, 1'b1, 10);

`ifdef SCAN_CTRL_MASK_EN
      // Counter chain gives 0100; bit 1 masked off hides the difference from 0110.
      mask_r[0] = 4'b0010;
      run_test(0, 4'b0011, 4'b0110, 1, 4'b0100, 1'b1, 10);
      mask_r[0] = 4'b0000;
      run_test(0, 4'b0011, 4'b0110, 1, 4'b0100, 1'b0, 10);
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
